// File: rtl/wb_gpio_ctrl_if.sv
// Wishbone classic slave bundle used by the GPIO peripheral.
// Signal names keep the bus-facing i_/o_ prefixes of the original pinout.
interface wb_gpio_ctrl_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO peripheral: debounced buttons with rising-edge interrupts,
// LEDs with per-bit output enable and a hardware blink mode.
module wb_gpio_ctrl #(
  parameter int unsigned NUM_BUTTONS     = 3,
  parameter int unsigned NUM_LEDS        = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_gpio_ctrl_if.slave          wb,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [NUM_LEDS-1:0]    led_enb,
  output logic                   irq
);

  localparam logic [5:0] REG_LED_OUT   = 6'h00;
  localparam logic [5:0] REG_LED_OE    = 6'h01;
  localparam logic [5:0] REG_BTN_IN    = 6'h02;
  localparam logic [5:0] REG_IRQ_STAT  = 6'h03;
  localparam logic [5:0] REG_IRQ_MASK  = 6'h04;
  localparam logic [5:0] REG_BLINK_EN  = 6'h05;
  localparam logic [5:0] REG_BLINK_DIV = 6'h06;

  localparam logic [23:0] BLINK_DIV_RST = 24'd1_000_000;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_LEDS-1:0]    led_out_q, led_out_d;
  logic [NUM_LEDS-1:0]    led_oe_q, led_oe_d;
  logic [NUM_LEDS-1:0]    blink_en_q, blink_en_d;
  logic [23:0]            blink_div_q, blink_div_d;
  logic [23:0]            blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic [NUM_LEDS-1:0]    leds_q, leds_d;
  logic [NUM_BUTTONS-1:0] irq_stat_q, irq_stat_d;
  logic [NUM_BUTTONS-1:0] irq_mask_q, irq_mask_d;
  logic                   irq_q, irq_d;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] db_q, db_d;
  logic [NUM_BUTTONS-1:0] rise;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];

  logic        sel_w, wr_stb;
  logic [5:0]  word;
  logic [31:0] cur, wr_val, clr_x;
  logic        unused_w;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = lanes[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return m;
  endfunction

  assign sel_w  = wb.i_wb_cyc & wb.i_wb_stb & (wb.i_wb_addr[31:8] == BASE_ADDR[31:8]);
  assign wr_stb = sel_w & ~ack_q & wb.i_wb_we;
  assign word   = wb.i_wb_addr[7:2];

  // Debounce: a bit only follows the synchronised pin after it has disagreed
  // for DEBOUNCE_CYCLES consecutive cycles; a 0->1 flip is an interrupt event.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    db_d = db_q;
    rise = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
          rise[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur = '0;
    unique case (word)
      REG_LED_OUT:   cur[NUM_LEDS-1:0]    = led_out_q;
      REG_LED_OE:    cur[NUM_LEDS-1:0]    = led_oe_q;
      REG_BTN_IN:    cur[NUM_BUTTONS-1:0] = db_q;
      REG_IRQ_STAT:  cur[NUM_BUTTONS-1:0] = irq_stat_q;
      REG_IRQ_MASK:  cur[NUM_BUTTONS-1:0] = irq_mask_q;
      REG_BLINK_EN:  cur[NUM_LEDS-1:0]    = blink_en_q;
      REG_BLINK_DIV: cur[23:0]            = blink_div_q;
      default:       cur = '0;
    endcase
    wr_val = merge_lanes(cur, wb.i_wb_data, wb.i_wb_sel);
    clr_x  = merge_lanes(32'h0, wb.i_wb_data, wb.i_wb_sel);

    ack_d   = sel_w & ~ack_q;
    rdata_d = ack_d ? cur : 32'h0;

    led_out_d   = (wr_stb && word == REG_LED_OUT)   ? wr_val[NUM_LEDS-1:0]    : led_out_q;
    led_oe_d    = (wr_stb && word == REG_LED_OE)    ? wr_val[NUM_LEDS-1:0]    : led_oe_q;
    irq_mask_d  = (wr_stb && word == REG_IRQ_MASK)  ? wr_val[NUM_BUTTONS-1:0] : irq_mask_q;
    blink_en_d  = (wr_stb && word == REG_BLINK_EN)  ? wr_val[NUM_LEDS-1:0]    : blink_en_q;
    blink_div_d = (wr_stb && word == REG_BLINK_DIV) ? wr_val[23:0]            : blink_div_q;

    // New edges are OR-ed in after the clear so a coincident event is never lost.
    irq_stat_d = irq_stat_q;
    if (wr_stb && word == REG_IRQ_STAT)
      irq_stat_d = irq_stat_q & ~clr_x[NUM_BUTTONS-1:0];
    irq_stat_d = irq_stat_d | rise;
    irq_d      = |(irq_stat_q & irq_mask_q);

    if (wr_stb && word == REG_BLINK_DIV) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q >= blink_div_q) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 24'd1;
      phase_d     = phase_q;
    end
    leds_d = (led_out_q & ~blink_en_q) | (led_out_q & blink_en_q & {NUM_LEDS{phase_q}});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      led_out_q   <= '0;
      led_oe_q    <= '0;
      blink_en_q  <= '0;
      blink_div_q <= BLINK_DIV_RST;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      leds_q      <= '0;
      irq_stat_q  <= '0;
      irq_mask_q  <= '0;
      irq_q       <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      // NOTE: the counter array is reset explicitly; it is state, not storage, so it must start at zero.
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      led_out_q   <= led_out_d;
      led_oe_q    <= led_oe_d;
      blink_en_q  <= blink_en_d;
      blink_div_q <= blink_div_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
      irq_stat_q  <= irq_stat_d;
      irq_mask_q  <= irq_mask_d;
      irq_q       <= irq_d;
      sync1_q     <= buttons;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign wb.o_wb_ack  = ack_q;
  assign wb.o_wb_data = rdata_q;
  assign leds         = leds_q;
  assign led_enb      = ~led_oe_q;
  assign irq          = irq_q;
  assign unused_w     = ^{wb.i_wb_addr[1:0], wr_val, clr_x};

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl with the default parameters
// (3 buttons, 8 LEDs, base 0x3000_0000, 16-cycle debounce).
module tb_wb_gpio_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] buttons;
  logic [7:0] leds;
  logic [7:0] led_enb;
  logic       irq;

  int checks = 0;
  int errors = 0;

  wb_gpio_ctrl_if wb ();

  wb_gpio_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .wb      (wb),
    .buttons (buttons),
    .leds    (leds),
    .led_enb (led_enb),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_stb  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_sel  = 4'h0;
    wb.i_wb_addr = 32'h0;
    wb.i_wb_data = 32'h0;
  endtask

  // One access; waits at most 10 edges for ack, then confirms ack is a one-cycle pulse.
  task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                     input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = we;
    wb.i_wb_sel  = sel;
    wb.i_wb_addr = addr;
    wb.i_wb_data = wdata;
    acked = 1'b0;
    rdata = 32'h0;
    for (int i = 0; i < 10 && !acked; i++) begin
      @(posedge clk); #1;
      if (wb.o_wb_ack === 1'b1) begin
        acked = 1'b1;
        rdata = wb.o_wb_data;
      end
    end
    if (acked) begin
      @(posedge clk); #1;
      checks++;
      if (wb.o_wb_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_pulse @%h: ack=%b required 0", addr, wb.o_wb_ack);
      end
    end
    bus_idle();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] rd;
    logic        ok;
    bus(BASE + {24'h0, off}, 1'b1, data, sel, rd, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack @%h: ack seen=%b required 1", off, ok);
    end
  endtask

  task automatic rd_expect(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    bus(BASE + {24'h0, off}, 1'b0, 32'h0, 4'hF, rd, ok);
    checks++;
    if (ok !== 1'b1 || rd !== exp) begin
      errors++;
      $display("FAIL %s: ack=%b data=%h required ack=1 data=%h", name, ok, rd, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp [7];
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000F_4240};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (leds !== 8'h00 || led_enb !== 8'hFF || irq !== 1'b0 ||
        wb.o_wb_ack !== 1'b0 || wb.o_wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: leds=%h enb=%h irq=%b ack=%b data=%h required 00 ff 0 0 0",
               leds, led_enb, irq, wb.o_wb_ack, wb.o_wb_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 7; r++)
      rd_expect($sformatf("reset_reg_%0d", r), 8'(4 * r), exp[r]);
    checks++;
    if (wb.o_wb_data !== 32'h0) begin
      errors++;
      $display("FAIL data_idle: data=%h required 0", wb.o_wb_data);
    end
  endtask

  task automatic test_leds();
    wr(8'h04, 32'h0000_000F, 4'b0001);
    wr(8'h00, 32'h0000_00A5, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led_enb !== 8'hF0 || leds !== 8'hA5) begin
      errors++;
      $display("FAIL led_drive: enb=%h leds=%h required f0 a5", led_enb, leds);
    end
    wr(8'h00, 32'h0000_FF00, 4'b0010);
    rd_expect("led_out_lane1", 8'h00, 32'h0000_00A5);
    rd_expect("led_oe_rb", 8'h04, 32'h0000_000F);
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    @(negedge clk);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_sel  = 4'hF;
    wb.i_wb_addr = BASE;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[5-i] = wb.o_wb_ack;
    end
    bus_idle();
    checks++;
    if (pat !== 6'b101010) begin
      errors++;
      $display("FAIL ack_held_stb: pattern=%b required 101010", pat);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    buttons[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    buttons[0] = 1'b0;
    repeat (30) @(posedge clk);
    rd_expect("glitch_btn_in", 8'h08, 32'h0);
    rd_expect("glitch_status", 8'h0C, 32'h0);
  endtask

  task automatic test_press_irq();
    int first;
    wr(8'h10, 32'h2, 4'hF);
    @(posedge clk); #1;
    buttons[1] = 1'b1;
    first = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (irq === 1'b1 && first == 0) first = e;
    end
    // BTN_IN and status flip at edge 18; the registered irq follows at 19.
    checks++;
    if (first != 19) begin
      errors++;
      $display("FAIL debounce_latency: irq first at edge %0d required 19", first);
    end
    rd_expect("press_btn_in", 8'h08, 32'h2);
    rd_expect("press_status", 8'h0C, 32'h2);
    wr(8'h0C, 32'h2, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq: irq=%b required 0", irq);
    end
    rd_expect("w1c_status", 8'h0C, 32'h0);
  endtask

  task automatic test_set_wins();
    buttons[1] = 1'b0;
    repeat (30) @(posedge clk);
    rd_expect("release_no_status", 8'h0C, 32'h0);
    @(posedge clk); #1;
    buttons[1] = 1'b1;
    repeat (17) @(posedge clk);
    wr(8'h0C, 32'h2, 4'hF);
    rd_expect("set_wins_status", 8'h0C, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_irq: irq=%b required 1", irq);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    wr(8'h00, 32'h01, 4'hF);
    wr(8'h14, 32'h01, 4'hF);
    wr(8'h18, 32'h03, 4'hF);
    // Divider write at edge k clears phase; leds lag phase by one edge, task returns after k+1.
    for (int c = 2; c <= 17; c++) begin
      @(posedge clk); #1;
      exp = {7'b0, 1'(((c - 1) / 4) % 2)};
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL blink_c%0d: leds=%h required %h", c, leds, exp);
      end
    end
  endtask

  task automatic test_window();
    logic [31:0] rd;
    logic        ok;
    bus(BASE + 32'h100, 1'b1, 32'hFF, 4'hF, rd, ok);
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL outside_no_ack: ack seen=%b required 0", ok);
    end
    rd_expect("outside_no_write", 8'h00, 32'h01);
    wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd_expect("unmapped_read", 8'h40, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b1;
    wb.i_wb_sel  = 4'hF;
    wb.i_wb_addr = BASE;
    wb.i_wb_data = 32'h5A;
    reset        = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb.o_wb_ack !== 1'b0 || leds !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: ack=%b leds=%h required 0 00", wb.o_wb_ack, leds);
    end
    bus_idle();
    @(negedge clk);
    reset = 1'b0;
    rd_expect("reset_mid_led_out", 8'h00, 32'h0);
  endtask

  initial begin
    bus_idle();
    buttons = 3'b000;
    reset   = 1'b1;
    test_reset();
    test_leds();
    test_back_to_back();
    test_glitch();
    test_press_irq();
    test_set_wins();
    test_blink();
    test_window();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
